disp_owner_arb: RTL and testbench
=================================

// Module: disp_owner_arb
// PURPOSE
// - Shares the single 8-digit seven-segment display between NREQ content sources (const instruction, menu, moving text, ...).
// - Each source raises req; one source at a time is granted, and its AN/segment codes are registered to the pins.
// - A minimum hold time prevents flicker; a maximum hold time forces preemption when others wait.
// - Replaces the per-state output case statement at the top of the display path with a sequenced round-robin owner.
// PARAMETERS
// - NREQ      3        number of requesting sources (2..8)
// - HOLD_MIN  1024     min cycles an owner keeps the display once granted
// - MAX_HOLD  1048576  cycles after which an owner is preempted if another req is pending (MAX_HOLD > HOLD_MIN)
// - BLANK_CYC 64       blank gap length between owners (used only with DISP_BLANK_EN)
// PORTS
// - clk       in   1        system clock; one clock; reset is synchronous and active-low
// - rst_n     in   1        synchronous active-low reset
// - req       in   NREQ     request per source; level, held while source wants the display
// - an_in     in   8*NREQ   anode pattern per source, slice i = [8*i+7:8*i], active-low
// - seg_in    in   7*NREQ   segment pattern per source, slice i = [7*i+6:7*i], active-low
// - gnt       out  NREQ     one-hot grant, registered
// - owner_id  out  3        index of current owner (valid when busy=1)
// - busy      out  1        1 while some source owns the display
// - AN        out  8        anode drive to pins, registered
// - led       out  7        segment drive to pins, registered
// BEHAVIOUR
// - Reset (rst_n=0 at a clk edge): state=IDLE, gnt=0, owner_id=0, busy=0, AN=8'hFF, led=7'h7F, hold_cnt=0, rr pointer so req[0] has top priority.
// - States: IDLE, OWN, BLANK (BLANK exists only with DISP_BLANK_EN).
// - IDLE: if |req, pick winner by round-robin (the last owner gets lowest priority); next cycle gnt=onehot(winner), busy=1, state=OWN, hold_cnt=0.
// - OWN: hold_cnt increments each cycle, saturating at MAX_HOLD-1.
// - OWN exits when (hold_cnt>=HOLD_MIN-1 and !req[owner]) or (hold_cnt>=MAX_HOLD-1 and any other req pending).
// - Release before HOLD_MIN: the grant and display are kept until HOLD_MIN is reached, still showing the owner's current an_in/seg_in.
// - Exit without DISP_BLANK_EN: re-arbitrate in the exit cycle over req with the old owner at lowest priority.
//   - Next cycle gnt switches directly to the new owner (zero gap), or goes to IDLE if no req.
//   - After preemption the old owner may win again only if it is the sole requester.
// - Pin outputs: AN/led <= busy-owner slice of an_in/seg_in, else 8'hFF/7'h7F.
//   - One cycle latency from an_in/seg_in, or from a gnt change, to the pins.
// - Simultaneous events:
//   - Owner drops req in the same cycle that MAX_HOLD expires: treated as a release.
//   - New req in the cycle of an exit: included in the arbitration.
// - Reset mid-OWN: immediate return to the reset values above; no output glitch beyond the blank value.
// - owner_id is sized for NREQ<=8; unused gnt bits are 0; gnt is never multi-hot.
// CONFIGURATION
// - DISP_BLANK_EN defined:
//   - On OWN exit, enter BLANK for exactly BLANK_CYC cycles: gnt=0, busy=0, AN=8'hFF, led=7'h7F.
//   - Then arbitrate as in IDLE (the old owner keeps lowest priority).
//   - Reqs arriving during BLANK wait.
// - DISP_BLANK_EN undefined: no BLANK state; owner switch is back-to-back as described above.
// STRUCTURE
// - disp_arb_pkg:
//   - state enum {IDLE, OWN, BLANK}
//   - DISP_AN_OFF=8'hFF and DISP_SEG_OFF=7'h7F
//   - function onehot_to_idx
// - Sub-module rr_pick: combinational round-robin selector (req, last_idx -> valid, win_idx); the FSM, counters and output registers stay in disp_owner_arb.
// TESTING (bench: NREQ=3, HOLD_MIN=16, MAX_HOLD=32, BLANK_CYC=4; an_in={8'hFB,8'hFD,8'hFE}, seg_in={7'h24,7'h79,7'h40})
// - Reset: rst_n=0 for 3 cycles with req=3'b111 -> gnt=0, busy=0, AN=8'hFF, led=7'h7F throughout.
// - Single req: req=3'b010 at cycle t -> gnt=3'b010, owner_id=1 at t+1; AN=8'hFD, led=7'h79 at t+2.
// - Early release: req=3'b001 held 5 cycles then dropped -> gnt=3'b001 held exactly 16 cycles, then IDLE with AN=8'hFF.
// - Contention: req=3'b111 held constantly -> owners 0,1,2,0 each for 32 cycles; gnt never multi-hot and never 0 between owners (macro off).
// - DISP_BLANK_EN on, same stimulus -> 4 cycles of gnt=0, AN=8'hFF between each pair of owners.
// - Reset mid-OWN: rst_n=0 at hold_cnt=10 of owner 2, then req=3'b101 -> after reset, source 0 is granted first.

Source files
------------

// File: rtl/disp_arb_pkg.sv
// disp_arb_pkg: shared types, blank pin codes and helpers for the display owner arbiter
package disp_arb_pkg;
  typedef enum logic [1:0] {IDLE, OWN, BLANK} state_t;
  localparam logic [7:0] DISP_AN_OFF  = 8'hFF;
  localparam logic [6:0] DISP_SEG_OFF = 7'h7F;
  function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
    logic [2:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r = r | (oh[i] ? 3'(i) : 3'd0);
    return r;
  endfunction
endpackage

// File: rtl/disp_owner_arb_rr_pick.sv
// rr_pick: combinational round-robin selector, the entry after last_idx has top priority
module rr_pick #(
  parameter int NREQ = 3
) (
  input  logic [NREQ-1:0] req,
  input  logic [2:0]      last_idx,
  output logic            valid,
  output logic [2:0]      win_idx
);
  logic [7:0] req8;
  logic [2:0] k;
  always_comb begin
    req8 = 8'(req);
    valid = |req;
    win_idx = '0;
    k = '0;
    // Walk from lowest to highest priority so the last hit wins.
    for (int i = NREQ; i >= 1; i--) begin
      k = 3'((int'(last_idx) + i) % NREQ);
      if (req8[k]) win_idx = k;
    end
  end
endmodule

// File: rtl/disp_owner_arb.sv
// disp_owner_arb: round-robin owner of the shared 8-digit seven-segment display
// Define DISP_BLANK_EN to insert a BLANK_CYC blank gap between owners.
module disp_owner_arb
  import disp_arb_pkg::*;
#(
  parameter int NREQ      = 3,
  parameter int HOLD_MIN  = 1024,
  parameter int MAX_HOLD  = 1048576,
  parameter int BLANK_CYC = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] an_in,
  input  logic [7*NREQ-1:0] seg_in,
  output logic [NREQ-1:0]   gnt,
  output logic [2:0]        owner_id,
  output logic              busy,
  output logic [7:0]        AN,
  output logic [6:0]        led
);
  localparam int CW = $clog2(MAX_HOLD);
  state_t        state;
  logic [CW-1:0] hold_cnt;
  logic [2:0]    last_idx, win_idx, cur;
  logic          win_valid, exit_own, own_arb, arb;
  logic [7:0]    req8;
  logic [7:0]    an_a [8];
  logic [6:0]    seg_a [8];
  rr_pick #(.NREQ(NREQ)) u_pick (
    .req      (req),
    .last_idx (last_idx),
    .valid    (win_valid),
    .win_idx  (win_idx)
  );
  always_comb begin
    req8 = 8'(req);
    cur = onehot_to_idx(8'(gnt));
    an_a = '{default: DISP_AN_OFF};
    seg_a = '{default: DISP_SEG_OFF};
    for (int i = 0; i < NREQ; i++) begin
      an_a[i] = an_in[8*i +: 8];
      seg_a[i] = seg_in[7*i +: 7];
    end
    // A drop of req at MAX_HOLD still counts as a release; either way we leave.
    exit_own = (hold_cnt >= CW'(HOLD_MIN-1) && !req8[cur]) ||
               (hold_cnt >= CW'(MAX_HOLD-1) && |(req & ~gnt));
  end
`ifdef DISP_BLANK_EN
  assign own_arb = 1'b0;
`else
  assign own_arb = exit_own;
`endif
  assign arb = state == IDLE || (state == OWN && own_arb) ||
               (state == BLANK && hold_cnt == CW'(BLANK_CYC-1));
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      gnt <= '0;
      owner_id <= '0;
      busy <= 1'b0;
      AN <= DISP_AN_OFF;
      led <= DISP_SEG_OFF;
      hold_cnt <= '0;
      last_idx <= 3'(NREQ-1);
    end else begin
      AN <= busy ? an_a[cur] : DISP_AN_OFF;
      led <= busy ? seg_a[cur] : DISP_SEG_OFF;
      if (arb) begin
        state <= win_valid ? OWN : IDLE;
        gnt <= win_valid ? NREQ'(1) << win_idx : '0;
        busy <= win_valid;
        hold_cnt <= '0;
        if (win_valid) begin
          owner_id <= win_idx;
          last_idx <= win_idx;
        end
      end else if (state == OWN && exit_own) begin
        state <= BLANK;
        gnt <= '0;
        busy <= 1'b0;
        hold_cnt <= '0;
      end else if (state != IDLE) begin
        hold_cnt <= hold_cnt == CW'(MAX_HOLD-1) ? hold_cnt : hold_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_disp_owner_arb.sv
// tb_disp_owner_arb: scoreboard bench; expected grant runs are queued by stimulus, checked by a monitor
module tb_disp_owner_arb;
`ifdef DISP_BLANK_EN
  localparam int GAP = 4;
`else
  localparam int GAP = 0;
`endif
  typedef struct {
    logic [2:0] g;
    int start;
    int len;
    int gap;
  } exp_t;

  logic        clk = 0;
  logic        rst_n;
  logic [2:0]  req;
  logic [23:0] an_in  = {8'hFB, 8'hFD, 8'hFE};
  logic [20:0] seg_in = {7'h24, 7'h79, 7'h40};
  logic [2:0]  gnt, owner_id;
  logic        busy;
  logic [7:0]  AN;
  logic [6:0]  led;

  logic [7:0] an_tab [3] = '{8'hFE, 8'hFD, 8'hFB};
  logic [6:0] seg_tab [3] = '{7'h40, 7'h79, 7'h24};
  exp_t q[$];
  int errors = 0, checks = 0, cyc = 0;
  bit mon_en = 0;
  logic       prev_rst = 0;
  logic [2:0] prev_g = 0, cur_g = 0;
  int run_start = 0, run_len = 0, run_gap = 0, zero_len = 1000;

  disp_owner_arb #(.NREQ(3), .HOLD_MIN(16), .MAX_HOLD(32), .BLANK_CYC(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .an_in(an_in), .seg_in(seg_in),
    .gnt(gnt), .owner_id(owner_id), .busy(busy), .AN(AN), .led(led)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int gidx(input logic [2:0] g);
    return g == 3'b010 ? 1 : g == 3'b100 ? 2 : 0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic end_run();
    exp_t e;
    if (q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_run: gnt=%b start=%0d len=%0d", cur_g, run_start, run_len);
    end else begin
      e = q.pop_front();
      chk("run_gnt", 32'(cur_g), 32'(e.g));
      chk("run_start", run_start, e.start);
      chk("run_len", run_len, e.len);
      if (e.gap >= 0) chk("run_gap", run_gap, e.gap);
    end
  endtask

  always @(negedge clk) if (mon_en) begin
    chk("AN", 32'(AN), (!prev_rst || prev_g == 0) ? 32'hFF : 32'(an_tab[gidx(prev_g)]));
    chk("led", 32'(led), (!prev_rst || prev_g == 0) ? 32'h7F : 32'(seg_tab[gidx(prev_g)]));
    chk("gnt_onehot0", 32'($onehot0(gnt)), 1);
    chk("busy", 32'(busy), 32'(gnt != 0));
    if (gnt != 0) chk("owner_id", 32'(owner_id), gidx(gnt));
    if (!prev_rst) chk("gnt_in_reset", 32'(gnt), 0);
    if (gnt != cur_g) begin
      if (cur_g != 0) end_run();
      if (gnt != 0) begin
        run_start = cyc;
        run_gap = zero_len;
        run_len = 0;
      end
      cur_g = gnt;
    end
    if (gnt == 0) zero_len++;
    else begin
      run_len++;
      zero_len = 0;
    end
    prev_rst = rst_n;
    prev_g = gnt;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [2:0] g, input int start, input int len, input int gap);
    exp_t e;
    e.g = g;
    e.start = start;
    e.len = len;
    e.gap = gap;
    q.push_back(e);
  endtask

  initial begin
    int b;
    rst_n = 0;
    req = 3'b111;
    @(posedge clk);
    #1;
    mon_en = 1;
    tick(2);
    rst_n = 1;
    req = 3'b000;
    tick(3);
    // Contention: 0,1,2,0 each preempted at MAX_HOLD, last one released.
    b = cyc;
    for (int k = 0; k < 4; k++)
      push(3'(1 << (k % 3)), b + 1 + k * (32 + GAP), k < 3 ? 32 : 32 - 3 * GAP, k == 0 ? -1 : GAP);
    req = 3'b111;
    tick(128);
    req = 3'b000;
    tick(40);
    // Single request held past HOLD_MIN.
    push(3'b010, cyc + 1, 20, -1);
    req = 3'b010;
    tick(20);
    req = 3'b000;
    tick(10);
    // Early release: grant kept for HOLD_MIN.
    push(3'b001, cyc + 1, 16, -1);
    req = 3'b001;
    tick(5);
    req = 3'b000;
    tick(30);
    // Reset in the middle of owner 2, then source 0 must win first.
    push(3'b100, cyc + 1, 11, -1);
    req = 3'b100;
    tick(11);
    rst_n = 0;
    req = 3'b101;
    tick(2);
    rst_n = 1;
    push(3'b001, cyc + 1, 20, -1);
    tick(20);
    req = 3'b000;
    for (int i = 0; i < 200 && q.size() > 0; i++) @(negedge clk);
    tick(5);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL missing_runs: %0d expected runs never seen, expected 0", q.size());
    end
    mon_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
